rv32_dbus_wb: RTL

bridges the memory stage's single-cycle data port to a Wishbone B4 classic master, stalling the pipeline until each access completes.

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, bus cycles without ack/err before a fault is forced (range 1..255).
REQ-002 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports read_in, write_in  input  1 each  load/store request from the memory stage (mutually exclusive).
REQ-005 SHALL have ports address_in  input  32, write_value_in  input  32, write_mask_in  input  4  access address, store data, byte enables.
REQ-006 SHALL have ports stall_in  input  1 (hazard stall of the memory stage) and flush_in  input  1 (memory stage flush).
REQ-007 SHALL have ports read_value_out  output  32  load data; fault_out  output  1  bus error or timeout; stall_out  output  1  stall request to hazard unit.
REQ-008 SHALL have Wishbone outputs wb_cyc_out 1, wb_stb_out 1, wb_we_out 1, wb_adr_out 30 (word address), wb_dat_out 32, wb_sel_out 4.
REQ-009 SHALL have Wishbone inputs wb_dat_in 32, wb_ack_in 1, wb_err_in 1.

Function
REQ-010 SHALL implement states IDLE, BUS, DONE.
REQ-011 IDLE: stall_out = (read_in|write_in) & !flush_in, combinationally; on such a request, next state BUS with request latched.
REQ-012 On IDLE->BUS SHALL register wb_adr_out=address_in[31:2], wb_we_out=write_in, wb_sel_out = write ? write_mask_in : 4'b1111, wb_dat_out=write_value_in; wb_cyc_out=wb_stb_out=1 from the next cycle.
REQ-013 BUS: stall_out=1; cyc/stb held and all Wishbone outputs stable until ack, err or timeout.
REQ-014 On wb_ack_in SHALL latch read_value_out=wb_dat_in (loads; unchanged for stores), fault_out=0, drop cyc/stb next cycle, go DONE.
REQ-015 On wb_err_in (priority over ack if both) SHALL set fault_out=1, drop cyc/stb, go DONE.
REQ-016 Timeout counter SHALL clear on entering BUS, increment each BUS cycle; reaching TIMEOUT_CYCLES without ack/err SHALL act as wb_err_in.
REQ-017 DONE: stall_out=0, read_value_out/fault_out held valid; a new request SHALL NOT be started while in DONE.
REQ-018 DONE->IDLE when !stall_in or flush_in; stays DONE while stall_in & !flush_in.
REQ-019 flush_in during BUS SHALL NOT abort the bus cycle; a discard flag SHALL be set, and on completion the state SHALL go IDLE (skipping DONE), fault_out=0.
REQ-020 fault_out SHALL be 0 in every state other than DONE.
REQ-021 Back-to-back accesses: minimum 3 cycles per access (IDLE, BUS with same-cycle ack, DONE).

Reset
REQ-022 reset SHALL override all other inputs: state IDLE, wb_cyc_out=wb_stb_out=wb_we_out=0, wb_sel_out=0, wb_adr_out=0, wb_dat_out=0, read_value_out=0, fault_out=0, timeout counter=0, discard=0.
REQ-023 reset during BUS SHALL drop cyc/stb in the following cycle; no response SHALL be reported.

Structure
REQ-024 State enum and the Wishbone word-address width constant SHALL live in the shared rv32 package.
REQ-025 No sub-module; single always_ff plus one always_comb for stall_out.

Verification
REQ-026 Load 0x100, ack after 2 BUS cycles, wb_dat_in=0xDEADBEEF -> wb_adr_out=0x40, sel=4'b1111, stall_out 1 for 3 cycles, DONE read_value_out=0xDEADBEEF, fault_out=0.
REQ-027 Store 0x203 mask 4'b1000 data 0xAB000000, immediate ack -> wb_we_out=1, wb_sel_out=4'b1000, wb_adr_out=0x80, DONE fault_out=0.
REQ-028 TIMEOUT_CYCLES=4, load with no ack -> cyc dropped after 4 BUS cycles, DONE fault_out=1.
REQ-029 wb_err_in and wb_ack_in together -> fault_out=1; stall_in held 3 cycles in DONE -> outputs stable, no new cyc.
REQ-030 flush_in in BUS then ack -> IDLE directly, fault_out stays 0; reset mid-BUS -> cyc/stb 0 next cycle, outputs at reset values.

---
 rtl/rv32_pkg.sv | 12 +
 rtl/rv32_dbus_wb.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/rv32_pkg.sv
// Shared rv32 core definitions used by the memory-stage data bus bridge.
package rv32_pkg;

  localparam int WB_ADR_W = 30;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_DONE = 2'd2
  } dbus_state_e;

endpackage

// File: rtl/rv32_dbus_wb.sv
// Memory-stage data port to Wishbone B4 classic master bridge.
// Holds the pipeline in stall while a single bus access is outstanding.
module rv32_dbus_wb
  import rv32_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                read_in,
  input  logic                write_in,
  input  logic [31:0]         address_in,
  input  logic [31:0]         write_value_in,
  input  logic [3:0]          write_mask_in,
  input  logic                stall_in,
  input  logic                flush_in,
  output logic [31:0]         read_value_out,
  output logic                fault_out,
  output logic                stall_out,
  output logic                wb_cyc_out,
  output logic                wb_stb_out,
  output logic                wb_we_out,
  output logic [WB_ADR_W-1:0] wb_adr_out,
  output logic [31:0]         wb_dat_out,
  output logic [3:0]          wb_sel_out,
  input  logic [31:0]         wb_dat_in,
  input  logic                wb_ack_in,
  input  logic                wb_err_in
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  dbus_state_e         state_q, state_d;
  logic                cyc_q, cyc_d;
  logic                we_q, we_d;
  logic [WB_ADR_W-1:0] adr_q, adr_d;
  logic [31:0]         dat_q, dat_d;
  logic [3:0]          sel_q, sel_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                fault_q, fault_d;
  logic [7:0]          tmo_q, tmo_d;
  logic                discard_q, discard_d;

  logic request;
  logic tmo_hit;
  logic err_hit;
  logic ack_hit;
  logic discard_now;
  logic unused_addr_bits;

  // Byte offset is carried by the select lines, not the word address.
  assign unused_addr_bits = ^address_in[1:0];

  assign request     = (read_in | write_in) & ~flush_in;
  assign tmo_hit     = (tmo_q == TMO_LAST);
  assign err_hit     = wb_err_in | (tmo_hit & ~wb_ack_in);
  assign ack_hit     = wb_ack_in & ~wb_err_in;
  assign discard_now = discard_q | flush_in;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    we_d      = we_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    sel_d     = sel_q;
    rdata_d   = rdata_q;
    fault_d   = fault_q;
    tmo_d     = tmo_q;
    discard_d = discard_q;
    stall_out = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        stall_out = request;
        if (request) begin
          state_d   = ST_BUS;
          cyc_d     = 1'b1;
          adr_d     = address_in[31:2];
          we_d      = write_in;
          sel_d     = write_in ? write_mask_in : 4'b1111;
          dat_d     = write_value_in;
          tmo_d     = 8'd0;
          discard_d = 1'b0;
          fault_d   = 1'b0;
        end
      end

      ST_BUS: begin
        stall_out = 1'b1;
        tmo_d     = tmo_q + 8'd1;
        if (err_hit | ack_hit) begin
          cyc_d     = 1'b0;
          tmo_d     = 8'd0;
          discard_d = 1'b0;
          if (ack_hit && !we_q) rdata_d = wb_dat_in;
          // A flushed access still completes on the bus, but nobody waits for it.
          if (discard_now) begin
            state_d = ST_IDLE;
            fault_d = 1'b0;
          end else begin
            state_d = ST_DONE;
            fault_d = err_hit;
          end
        end else begin
          discard_d = discard_now;
        end
      end

      ST_DONE: begin
        if (!stall_in || flush_in) begin
          state_d = ST_IDLE;
          fault_d = 1'b0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cyc_q     <= 1'b0;
      we_q      <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      sel_q     <= '0;
      rdata_q   <= '0;
      fault_q   <= 1'b0;
      tmo_q     <= '0;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      we_q      <= we_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      sel_q     <= sel_d;
      rdata_q   <= rdata_d;
      fault_q   <= fault_d;
      tmo_q     <= tmo_d;
      discard_q <= discard_d;
    end
  end

  assign wb_cyc_out     = cyc_q;
  assign wb_stb_out     = cyc_q;
  assign wb_we_out      = we_q;
  assign wb_adr_out     = adr_q;
  assign wb_dat_out     = dat_q;
  assign wb_sel_out     = sel_q;
  assign read_value_out = rdata_q;
  assign fault_out      = fault_q;

endmodule
